// File: rtl/lane_pkg.sv
// Shared image geometry and scheduler state encoding for the output image BRAM.
package lane_pkg;

    localparam int WIDTH      = 1280;
    localparam int HEIGHT     = 720;
    localparam int IMAGE_SIZE = WIDTH * HEIGHT;
    localparam int ADDR_W     = $clog2(IMAGE_SIZE);
    localparam int PIXEL_W    = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PROC = 2'd2,
        ST_READ = 2'd3
    } sched_state_t;

endpackage

// File: rtl/bram_rd_pipe.sv
// Valid-only delay line that tracks BRAM read requests until their data returns.
module bram_rd_pipe #(
    parameter int LATENCY = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic flush,
    input  logic in_valid,
    output logic out_valid,
    output logic empty
);

    localparam logic [LATENCY-1:0] LAST_STAGE = LATENCY'(1) << (LATENCY - 1);

    logic [LATENCY-1:0] vld;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld <= '0;
        end else if (flush) begin
            vld <= '0;
        end else begin
            vld[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    assign out_valid = vld[LATENCY-1];

    // Empty once the beat now at the output leaves: nothing entering, nothing behind it.
    assign empty = !in_valid && ((vld & ~LAST_STAGE) == '0);

endmodule

// File: rtl/image_bram_sched.sv
// Frame-phase scheduler sharing one single-port image BRAM between loader, highlight and readout.
module image_bram_sched
    import lane_pkg::*;
#(
    parameter int WIDTH        = lane_pkg::WIDTH,
    parameter int HEIGHT       = lane_pkg::HEIGHT,
    parameter int IMAGE_SIZE   = WIDTH * HEIGHT,
    parameter int ADDR_W       = $clog2(IMAGE_SIZE),
    parameter int PIXEL_W      = lane_pkg::PIXEL_W,
    parameter int READ_LATENCY = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [ADDR_W-1:0]  ld_addr,
    input  logic [PIXEL_W-1:0] ld_data,
    input  logic               ld_last,
    output logic               hough_start,
    input  logic               highlight_done,
    input  logic               hl_wr_en,
    input  logic [ADDR_W-1:0]  hl_wr_addr,
    input  logic [PIXEL_W-1:0] hl_wr_data,
    input  logic               rd_valid,
    output logic               rd_ready,
    input  logic [ADDR_W-1:0]  rd_addr,
    input  logic               rd_last,
    output logic               rd_data_valid,
    output logic [PIXEL_W-1:0] rd_data,
    output logic               bram_en,
    output logic               bram_we,
    output logic [ADDR_W-1:0]  bram_addr,
    output logic [PIXEL_W-1:0] bram_wr_data,
    input  logic [PIXEL_W-1:0] bram_rd_data,
    output logic               busy,
    output logic               frame_done,
    output logic [15:0]        hl_drop_count
);

    sched_state_t state;
    logic         hl_done_q;
    logic         drain_q;
    logic         rd_accept;
    logic         ld_accept;
    logic         pipe_valid;
    logic         pipe_empty;

    assign ld_ready  = (state == ST_LOAD);
    // Once the last read is accepted, stop taking requests and only drain.
    assign rd_ready  = (state == ST_READ) && !drain_q;
    assign ld_accept = ld_ready && ld_valid;
    assign rd_accept = rd_ready && rd_valid;
    assign busy      = (state != ST_IDLE);

    always_comb begin
        bram_en      = 1'b0;
        bram_we      = 1'b0;
        bram_addr    = '0;
        bram_wr_data = '0;
        case (state)
            ST_LOAD: begin
                if (ld_valid) begin
                    bram_en      = 1'b1;
                    bram_we      = 1'b1;
                    bram_addr    = ld_addr;
                    bram_wr_data = ld_data;
                end
            end
            ST_PROC: begin
                if (hl_wr_en) begin
                    bram_en      = 1'b1;
                    bram_we      = 1'b1;
                    bram_addr    = hl_wr_addr;
                    bram_wr_data = hl_wr_data;
                end
            end
            ST_READ: begin
                if (rd_accept) begin
                    bram_en   = 1'b1;
                    bram_addr = rd_addr;
                end
            end
            default: ;
        endcase
    end

    bram_rd_pipe #(
        .LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clock     (clock),
        .reset     (reset),
        .flush     (state == ST_IDLE),
        .in_valid  (rd_accept),
        .out_valid (pipe_valid),
        .empty     (pipe_empty)
    );

    assign rd_data_valid = pipe_valid;
    assign rd_data       = pipe_valid ? bram_rd_data : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            hl_done_q   <= 1'b0;
            drain_q     <= 1'b0;
            hough_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            hough_start <= 1'b0;
            frame_done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (ld_accept && ld_last) begin
                        state       <= ST_PROC;
                        hough_start <= 1'b1;
                    end
                end
                ST_PROC: begin
                    if (hl_done_q) begin
                        state     <= ST_READ;
                        hl_done_q <= 1'b0;
                    end else if (highlight_done) begin
                        hl_done_q <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (rd_accept && rd_last) begin
                        drain_q <= 1'b1;
                    end
                    // Leave as the final beat is returned so frame_done follows it.
                    if (drain_q && pipe_empty) begin
                        state      <= ST_IDLE;
                        drain_q    <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hl_drop_count <= '0;
        end else if (hl_wr_en && (state != ST_PROC) && (hl_drop_count != 16'hFFFF)) begin
            hl_drop_count <= hl_drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_image_bram_sched.sv
// Directed bench for image_bram_sched: full frame, highlight, readback, drops, reset mid-frame.
module tb_image_bram_sched;

    localparam int ADDR_W  = 20;
    localparam int PIXEL_W = 24;

    logic               clock = 1'b0;
    logic               reset;
    logic               frame_start;
    logic               ld_valid;
    logic               ld_ready;
    logic [ADDR_W-1:0]  ld_addr;
    logic [PIXEL_W-1:0] ld_data;
    logic               ld_last;
    logic               hough_start;
    logic               highlight_done;
    logic               hl_wr_en;
    logic [ADDR_W-1:0]  hl_wr_addr;
    logic [PIXEL_W-1:0] hl_wr_data;
    logic               rd_valid;
    logic               rd_ready;
    logic [ADDR_W-1:0]  rd_addr;
    logic               rd_last;
    logic               rd_data_valid;
    logic [PIXEL_W-1:0] rd_data;
    logic               bram_en;
    logic               bram_we;
    logic [ADDR_W-1:0]  bram_addr;
    logic [PIXEL_W-1:0] bram_wr_data;
    logic [PIXEL_W-1:0] bram_rd_data;
    logic               busy;
    logic               frame_done;
    logic [15:0]        hl_drop_count;

    int checks = 0;
    int errors = 0;

    logic [PIXEL_W-1:0] mem [16];
    logic [3:0]         mem_idx;

    always #5 clock = ~clock;

    image_bram_sched #(.READ_LATENCY(1)) dut (
        .clock          (clock),
        .reset          (reset),
        .frame_start    (frame_start),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
        .ld_last        (ld_last),
        .hough_start    (hough_start),
        .highlight_done (highlight_done),
        .hl_wr_en       (hl_wr_en),
        .hl_wr_addr     (hl_wr_addr),
        .hl_wr_data     (hl_wr_data),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_addr        (rd_addr),
        .rd_last        (rd_last),
        .rd_data_valid  (rd_data_valid),
        .rd_data        (rd_data),
        .bram_en        (bram_en),
        .bram_we        (bram_we),
        .bram_addr      (bram_addr),
        .bram_wr_data   (bram_wr_data),
        .bram_rd_data   (bram_rd_data),
        .busy           (busy),
        .frame_done     (frame_done),
        .hl_drop_count  (hl_drop_count)
    );

    // Small single-port BRAM, one-cycle read latency, keyed on the low address bits.
    assign mem_idx = bram_addr[3:0];
    always @(posedge clock) begin
        if (bram_en) begin
            if (bram_we) mem[mem_idx] <= bram_wr_data;
            else         bram_rd_data <= mem[mem_idx];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {24'd0, ld_ready, rd_ready, bram_en, bram_we,
                            rd_data_valid, hough_start, busy, frame_done}, 32'd0);
        chk({tag, "_addr"}, {12'd0, bram_addr}, 32'd0);
        chk({tag, "_wd"}, {8'd0, bram_wr_data}, 32'd0);
        chk({tag, "_rd"}, {8'd0, rd_data}, 32'd0);
        chk({tag, "_drops"}, {16'd0, hl_drop_count}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; frame_start = 0; ld_valid = 0; ld_addr = '0; ld_data = '0; ld_last = 0;
        highlight_done = 0; hl_wr_en = 0; hl_wr_addr = '0; hl_wr_data = '0;
        rd_valid = 0; rd_addr = '0; rd_last = 0; bram_rd_data = '0;
        #3;
        chk_all_zero("reset");
        #9 reset = 1'b0;
        tick();

        // Drops in IDLE, with a readout request already pending
        rd_valid = 1; rd_addr = 20'd0;
        hl_wr_en = 1; hl_wr_addr = 20'd5; hl_wr_data = 24'hABCDEF;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("idle_hl_no_write", {31'd0, bram_en}, 32'd0);
            chk("idle_rd_ready", {31'd0, rd_ready}, 32'd0);
            tick();
        end
        hl_wr_en = 0;
        settle();
        chk("idle_drops", {16'd0, hl_drop_count}, 32'd3);

        // Frame start
        frame_start = 1;
        settle();
        chk("idle_busy", {31'd0, busy}, 32'd0);
        tick();
        frame_start = 0;
        settle();
        chk("load_busy", {31'd0, busy}, 32'd1);
        chk("load_ld_ready", {31'd0, ld_ready}, 32'd1);

        // Four loader beats, highlight strobes on the first two are dropped
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1; ld_addr = ADDR_W'(i); ld_data = PIXEL_W'((i + 1) * 24'h111111);
            ld_last = (i == 3);
            hl_wr_en = (i < 2);
            settle();
            chk("load_we", {30'd0, bram_en, bram_we}, 32'd3);
            chk("load_addr", {12'd0, bram_addr}, 32'(i));
            chk("load_wd", {8'd0, bram_wr_data}, 32'((i + 1) * 24'h111111));
            chk("load_rd_ready", {31'd0, rd_ready}, 32'd0);
            chk("load_hough", {31'd0, hough_start}, 32'd0);
            tick();
        end
        ld_valid = 0; ld_last = 0; hl_wr_en = 0;
        settle();
        chk("proc_hough", {31'd0, hough_start}, 32'd1);
        chk("proc_busy", {31'd0, busy}, 32'd1);
        chk("load_drops", {16'd0, hl_drop_count}, 32'd5);
        chk("proc_ld_ready", {31'd0, ld_ready}, 32'd0);
        chk("proc_rd_ready", {31'd0, rd_ready}, 32'd0);

        // frame_start in PROC is ignored
        frame_start = 1;
        tick();
        frame_start = 0;
        settle();
        chk("proc_hough_once", {31'd0, hough_start}, 32'd0);
        chk("proc_fs_ignored", {30'd0, ld_ready, rd_ready}, 32'd0);

        // Highlight write together with highlight_done
        hl_wr_en = 1; hl_wr_addr = 20'd1; hl_wr_data = 24'h0000FF; highlight_done = 1;
        settle();
        chk("hl_we", {30'd0, bram_en, bram_we}, 32'd3);
        chk("hl_addr", {12'd0, bram_addr}, 32'd1);
        chk("hl_wd", {8'd0, bram_wr_data}, 32'h0000FF);
        tick();
        hl_wr_en = 0; highlight_done = 0;
        settle();
        chk("hl_rd_ready_1", {31'd0, rd_ready}, 32'd0);
        tick();
        chk("hl_rd_ready_2", {31'd0, rd_ready}, 32'd1);
        chk("proc_drops", {16'd0, hl_drop_count}, 32'd5);

        // Readback: the held request at addr 0 is accepted now
        chk("rd_en", {30'd0, bram_en, bram_we}, 32'd2);
        chk("rd_addr0", {12'd0, bram_addr}, 32'd0);
        tick();
        rd_addr = 20'd1;
        settle();
        chk("rd_dv0", {31'd0, rd_data_valid}, 32'd1);
        chk("rd_data0", {8'd0, rd_data}, 32'h111111);
        tick();
        rd_addr = 20'd2;
        settle();
        chk("rd_data1", {8'd0, rd_data}, 32'h0000FF);
        tick();
        rd_addr = 20'd3; rd_last = 1;
        settle();
        chk("rd_data2", {8'd0, rd_data}, 32'h333333);
        tick();
        rd_valid = 0; rd_last = 0;
        settle();
        chk("rd_dv3", {31'd0, rd_data_valid}, 32'd1);
        chk("rd_data3", {8'd0, rd_data}, 32'h444444);
        chk("rd_drain_ready", {31'd0, rd_ready}, 32'd0);
        chk("rd_fd_early", {31'd0, frame_done}, 32'd0);
        tick();
        chk("frame_done", {31'd0, frame_done}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_dv", {31'd0, rd_data_valid}, 32'd0);
        tick();
        chk("frame_done_pulse", {31'd0, frame_done}, 32'd0);

        // Second frame, reset while a read is in flight
        frame_start = 1;
        tick();
        frame_start = 0;
        ld_valid = 1; ld_addr = 20'd0; ld_data = 24'h555555; ld_last = 1;
        tick();
        ld_valid = 0; ld_last = 0; highlight_done = 1;
        tick();
        highlight_done = 0;
        tick();
        tick();
        chk("r2_rd_ready", {31'd0, rd_ready}, 32'd1);
        rd_valid = 1; rd_addr = 20'd2;
        tick();
        rd_valid = 0;
        settle();
        chk("r2_inflight", {31'd0, rd_data_valid}, 32'd1);
        reset = 1;
        settle();
        chk_all_zero("midreset");
        tick();
        reset = 0;
        tick();
        chk("post_reset_busy", {31'd0, busy}, 32'd0);
        chk("post_reset_dv", {31'd0, rd_data_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
